// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared types and widths for the PSRAM arbiter
// Contents: ArbState FSM encoding, MAX_REQ requester ceiling, ADDR_W/DATA_W widths.
package psram_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ArbState;

endpackage

// File: rtl/psram_rr_picker.sv
// rtl/psram_rr_picker.sv - combinational round-robin winner selection
// Ports:
//   i_req    - request vector, zero-padded to MAX_REQ
//   i_ptr    - index of the last granted requester; search starts at i_ptr+1
//   i_prio0  - 1: requester 0 wins outright, the rest rotate among themselves
//   o_winner - index of the selected requester
//   o_valid  - 1 when any request is present
module psram_rr_picker
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [MAX_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  input  logic               i_prio0,
  output logic [1:0]         o_winner,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] req_rr;
  logic [2:0]         idx;

  always_comb begin
    req_rr   = i_req;
    o_winner = '0;
    o_valid  = 1'b0;
    idx      = '0;
    // Under priority mode requester 0 never takes part in the rotation.
    if (i_prio0) begin
      req_rr[0] = 1'b0;
    end
    if (i_prio0 && i_req[0]) begin
      o_valid = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = {1'b0, i_ptr} + 3'(i);
        if (idx >= 3'(NUM_REQ)) begin
          idx = idx - 3'(NUM_REQ);
        end
        if (!o_valid && req_rr[idx[1:0]]) begin
          o_valid  = 1'b1;
          o_winner = idx[1:0];
        end
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - serialises up to four requesters onto the memCtrl request port
// Option macro: PSRAM_ARB_PRIO0_EN gives requester 0 absolute priority.
// Ports:
//   i_clkRAM, reset          - RAM clock, synchronous active-high reset
//   i_req/i_write/i_bank     - per-requester request level, direction, bank
//   i_address/i_dataToWrite  - packed per-requester address and write byte
//   o_done                   - one-cycle completion pulse to the granted requester
//   o_dataRead               - last read byte, held until the next read completes
//   o_grantId, o_active      - current/last grant, transaction-owned flag
//   o_mem_*                  - memCtrl request (active-low cs) and latched fields
//   i_mem_busy/dataReady/dataRead - memCtrl status and read data
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      i_clkRAM,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_address,
  input  logic [NUM_REQ-1:0]        i_bank,
  input  logic [NUM_REQ*DATA_W-1:0] i_dataToWrite,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_dataRead,
  output logic [1:0]                o_grantId,
  output logic                      o_active,
  output logic                      o_mem_cs,
  output logic                      o_mem_write,
  output logic                      o_mem_bank,
  output logic [ADDR_W-1:0]         o_mem_address,
  output logic [DATA_W-1:0]         o_mem_dataToWrite,
  input  logic                      i_mem_busy,
  input  logic                      i_mem_dataReady,
  input  logic [DATA_W-1:0]         i_mem_dataRead
);

`ifdef PSRAM_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  ArbState             state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                write_q, write_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [1:0]          pick_idx;
  logic                pick_vld;
  logic [NUM_REQ-1:0]  done_vec;
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = i_address[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = i_dataToWrite[k*DATA_W +: DATA_W];
  end

  psram_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req    (MAX_REQ'(i_req)),
    .i_ptr    (ptr_q),
    .i_prio0  (PRIO0),
    .o_winner (pick_idx),
    .o_valid  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rdata_d = rdata_q;
    write_d = write_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // memCtrl reports busy during its power-up init; hold off grants.
        if (pick_vld && !i_mem_busy) begin
          grant_d = pick_idx;
          write_d = i_write[pick_idx];
          bank_d  = i_bank[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_busy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_mem_busy) begin
          if (!write_q) begin
            rdata_d = i_mem_dataRead;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // A priority grant to requester 0 leaves the rotation untouched.
        if (!(PRIO0 && grant_q == 2'd0)) begin
          ptr_d = grant_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'(NUM_REQ - 1);
      grant_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    done_vec = '0;
    if (state_q == DONE) begin
      done_vec[grant_q] = 1'b1;
    end
  end

  // cs is low exactly in ISSUE and WAIT, so DONE+IDLE give the 2-cycle
  // high gap memCtrl's falling-edge detector needs to re-arm.
  assign o_mem_cs          = !(state_q == ISSUE || state_q == WAIT);
  assign o_active          = (state_q != IDLE);
  assign o_done            = done_vec;
  assign o_dataRead        = rdata_q;
  assign o_grantId         = grant_q;
  assign o_mem_write       = write_q;
  assign o_mem_bank        = bank_q;
  assign o_mem_address     = addr_q;
  assign o_mem_dataToWrite = wdata_q;

`ifndef SYNTHESIS
  // A read may only leave WAIT when memCtrl flags its data as valid.
  a_read_exit_ready: assert property (
    @(posedge i_clkRAM) disable iff (reset)
      (state_q == WAIT && !i_mem_busy && !write_q) |-> i_mem_dataReady
  );
`endif

endmodule
